bus_dest_bank: RTL and testbench
================================

Name: bus_dest_bank

Overview:
- Write side of the 32-bit datapath bus: captures the bus value into the destination register selected by a 5-bit destination code.
- Holds the CPU-visible registers and presents them as parallel outputs to the bus source multiplexer.
- Supports single-beat writes and a two-beat 64-bit HI/LO pair write, plus PC auto-increment.
- Tracks and reports invalid destination codes.

Parameters:
- DATA_W, 32, bus and register width
- PC_STEP, 4, PC auto-increment amount
- CNT_W, 16, accepted-write counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- bus_in  in  DATA_W  bus value to capture
- dcode  in  5  destination code
- wr_valid  in  1  write request
- wr_pair  in  1  with dcode=16: this beat writes HI, the next accepted beat writes LO
- wr_ready  out  1  block can accept a beat
- pc_inc  in  1  PC <= PC + PC_STEP
- err_clr  in  1  clear sticky error
- gpr_q  out  16*DATA_W  R0..R15 flattened, R0 in bits [DATA_W-1:0]
- hi_q, lo_q, y_q, mar_q, pc_q, mdr_q, outport_q, ir_q  out  DATA_W each  register contents
- pair_busy  out  1  waiting for the LO beat
- err  out  1  sticky invalid-code flag
- err_code  out  5  first offending code
- wr_count  out  CNT_W  accepted-beat count, saturating

Behaviour:
- Destination code map:
  - 0-15: R0-R15
  - 16: HI
  - 17: LO
  - 18: Y
  - 19: MAR
  - 20: PC
  - 21: MDR
  - 22: OUTPORT
  - 23: IR
  - 24-31: invalid
- Reset (rst_n low, async): every register = 0, err = 0, err_code = 0, wr_count = 0, FSM = IDLE, pair_busy = 0, wr_ready = 0 while asserted.
- A beat is accepted on a rising edge with wr_valid & wr_ready. The target register holds bus_in from the next cycle (1-cycle latency). There is no combinational bus_in -> q path.
- wr_ready = !err, driven from registered state only.
- FSM IDLE:
  - Accepted beat with valid code: writes the decoded register.
  - If dcode=16 and wr_pair=1: write HI, go to PAIR_LO, pair_busy = 1.
  - wr_pair with any other dcode is ignored (single write).
- FSM PAIR_LO:
  - The next accepted beat writes LO regardless of dcode and wr_pair, then returns to IDLE.
  - Cycles with no accepted beat stay in PAIR_LO indefinitely.
- Invalid code accepted in IDLE:
  - No register written.
  - err = 1 and err_code = dcode, both latched on the first invalid code only.
  - wr_ready falls on the next cycle.
- err_clr clears err (wr_ready rises the next cycle). err_code holds its last value. err_clr has no effect on FSM state.
- err_clr and a new invalid code on the same edge cannot occur, since wr_ready = 0 while err = 1.
- wr_count increments on every accepted beat, invalid ones included, and saturates at all-ones.
- PC: an accepted bus write to PC on the same edge as pc_inc wins, and pc_inc is dropped. PC otherwise wraps modulo 2^DATA_W.
- Reset asserted in PAIR_LO abandons the pair: FSM returns to IDLE and LO is cleared to 0.

Optional Feature:
- BUS_DEST_R0_ZERO_EN
  - Defined: writes to code 0 are accepted and counted but discarded; gpr_q[R0] is constant 0.
  - Undefined: R0 is an ordinary register.

Decomposition:
- Shared package holds:
  - destination-code localparams (DST_R0..DST_R15, DST_HI, DST_LO, DST_Y, DST_MAR, DST_PC, DST_MDR, DST_OUTPORT, DST_IR, DST_FIRST_INVALID=24)
  - FSM state enum {IDLE, PAIR_LO}
  - the source-code constants for the bus mux, so both ends share one map
- One sub-module, dest_decoder_5to32: combinational code -> one-hot write enables, gated by accept, with invalid detect.

Test Plan:
- Reset release, then bus_in=32'hDEADBEEF, dcode=5, 1-beat valid -> next cycle R5=DEADBEEF, all other registers 0, wr_count=1.
- dcode=16, wr_pair=1, bus=32'h1 followed by dcode=3 (ignored), bus=32'h2 -> HI=1, LO=2, R3 unchanged, pair_busy high exactly between the beats.
- PC=0x100: pc_inc for 3 cycles -> 0x10C. Then pc_inc together with write dcode=20, bus=0x400 -> PC=0x400.
- dcode=27 accepted -> err=1, err_code=27, wr_ready=0 next cycle, a following valid beat is not accepted; err_clr -> wr_ready=1 the next cycle.
- Preload wr_count to all-ones minus 1, then 3 beats -> wr_count saturates at 0xFFFF.
- Assert rst_n low mid-cycle while in PAIR_LO -> outputs 0 immediately, FSM IDLE. With BUS_DEST_R0_ZERO_EN, a write to dcode=0 with 0xFFFFFFFF leaves R0=0.

Source files
------------

// File: rtl/bus_dest_bank_pkg.sv
// Shared definitions for the bus destination bank and the bus source mux.
// Destination and source codes use the same map, so both ends of the bus agree.
package bus_dest_bank_pkg;

   localparam int unsigned CODE_W  = 5;
   localparam int unsigned NUM_GPR = 16;
   localparam int unsigned NUM_DST = 24;

   localparam logic [CODE_W-1:0] DST_R0            = 5'd0;
   localparam logic [CODE_W-1:0] DST_R1            = 5'd1;
   localparam logic [CODE_W-1:0] DST_R2            = 5'd2;
   localparam logic [CODE_W-1:0] DST_R3            = 5'd3;
   localparam logic [CODE_W-1:0] DST_R4            = 5'd4;
   localparam logic [CODE_W-1:0] DST_R5            = 5'd5;
   localparam logic [CODE_W-1:0] DST_R6            = 5'd6;
   localparam logic [CODE_W-1:0] DST_R7            = 5'd7;
   localparam logic [CODE_W-1:0] DST_R8            = 5'd8;
   localparam logic [CODE_W-1:0] DST_R9            = 5'd9;
   localparam logic [CODE_W-1:0] DST_R10           = 5'd10;
   localparam logic [CODE_W-1:0] DST_R11           = 5'd11;
   localparam logic [CODE_W-1:0] DST_R12           = 5'd12;
   localparam logic [CODE_W-1:0] DST_R13           = 5'd13;
   localparam logic [CODE_W-1:0] DST_R14           = 5'd14;
   localparam logic [CODE_W-1:0] DST_R15           = 5'd15;
   localparam logic [CODE_W-1:0] DST_HI            = 5'd16;
   localparam logic [CODE_W-1:0] DST_LO            = 5'd17;
   localparam logic [CODE_W-1:0] DST_Y             = 5'd18;
   localparam logic [CODE_W-1:0] DST_MAR           = 5'd19;
   localparam logic [CODE_W-1:0] DST_PC            = 5'd20;
   localparam logic [CODE_W-1:0] DST_MDR           = 5'd21;
   localparam logic [CODE_W-1:0] DST_OUTPORT       = 5'd22;
   localparam logic [CODE_W-1:0] DST_IR            = 5'd23;
   localparam logic [CODE_W-1:0] DST_FIRST_INVALID = 5'd24;

   // Source-side codes for the bus mux, tied to the destination map.
   localparam logic [CODE_W-1:0] SRC_R0      = DST_R0;
   localparam logic [CODE_W-1:0] SRC_R15     = DST_R15;
   localparam logic [CODE_W-1:0] SRC_HI      = DST_HI;
   localparam logic [CODE_W-1:0] SRC_LO      = DST_LO;
   localparam logic [CODE_W-1:0] SRC_Y       = DST_Y;
   localparam logic [CODE_W-1:0] SRC_MAR     = DST_MAR;
   localparam logic [CODE_W-1:0] SRC_PC      = DST_PC;
   localparam logic [CODE_W-1:0] SRC_MDR     = DST_MDR;
   localparam logic [CODE_W-1:0] SRC_OUTPORT = DST_OUTPORT;
   localparam logic [CODE_W-1:0] SRC_IR      = DST_IR;

   typedef enum logic {
      IDLE    = 1'b0,
      PAIR_LO = 1'b1
   } state_e;

   // True for codes that name a real register.
   function automatic logic is_valid_dst(input logic [CODE_W-1:0] code);
      return code < DST_FIRST_INVALID;
   endfunction

endpackage

// File: rtl/bus_dest_bank_dest_decoder.sv
// Destination code to one-hot register write enables, gated by beat acceptance.
module dest_decoder_5to32
   import bus_dest_bank_pkg::*;
(
   input  logic [CODE_W-1:0]  code_i,
   input  logic               accept_i,
   output logic [NUM_DST-1:0] we_o,
   output logic               invalid_o
);

   // One enable per register; codes past the map only raise invalid.
   always_comb begin
      we_o      = '0;
      invalid_o = 1'b0;
      for (int i = 0; i < int'(NUM_DST); i++) begin
         we_o[i] = accept_i && (code_i == CODE_W'(i));
      end
      invalid_o = accept_i && !is_valid_dst(code_i);
   end

endmodule

// File: rtl/bus_dest_bank.sv
// Write side of the datapath bus: captures bus_in into the register chosen by
// dcode, with HI/LO pair writes, PC auto-increment and sticky invalid-code error.
// Build option: BUS_DEST_R0_ZERO_EN makes R0 a constant zero (writes discarded).
module bus_dest_bank
   import bus_dest_bank_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned PC_STEP = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     bus_in,
   input  logic [CODE_W-1:0]     dcode,
   input  logic                  wr_valid,
   input  logic                  wr_pair,
   output logic                  wr_ready,
   input  logic                  pc_inc,
   input  logic                  err_clr,
   output logic [16*DATA_W-1:0]  gpr_q,
   output logic [DATA_W-1:0]     hi_q,
   output logic [DATA_W-1:0]     lo_q,
   output logic [DATA_W-1:0]     y_q,
   output logic [DATA_W-1:0]     mar_q,
   output logic [DATA_W-1:0]     pc_q,
   output logic [DATA_W-1:0]     mdr_q,
   output logic [DATA_W-1:0]     outport_q,
   output logic [DATA_W-1:0]     ir_q,
   output logic                  pair_busy,
   output logic                  err,
   output logic [CODE_W-1:0]     err_code,
   output logic [CNT_W-1:0]      wr_count
);

   state_e               state_q, state_d;
   logic                 ready_q, ready_d;
   logic                 err_q, err_d;
   logic [CODE_W-1:0]    err_code_q, err_code_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]    rf_q [NUM_DST];

   logic                 accept;
   logic [CODE_W-1:0]    code_eff;
   logic [NUM_DST-1:0]   we;
   logic                 invalid;

   assign accept   = wr_valid & ready_q;
   // The second beat of a pair always lands in LO, whatever code rides with it.
   assign code_eff = (state_q == PAIR_LO) ? DST_LO : dcode;

   dest_decoder_5to32 u_dec (
      .code_i    (code_eff),
      .accept_i  (accept),
      .we_o      (we),
      .invalid_o (invalid)
   );

   // Next-state logic for the pair FSM, error tracking and beat counter.
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE:    if (accept && dcode == DST_HI && wr_pair) state_d = PAIR_LO;
         PAIR_LO: if (accept) state_d = IDLE;
      endcase
      if (err_clr) err_d = 1'b0;
      if (invalid && !err_q) begin
         err_d      = 1'b1;
         err_code_d = dcode;
      end
      if (accept && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      // Ready is a flop so it stays low through reset and never sees bus inputs.
      ready_d = ~err_d;
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         cnt_q      <= cnt_d;
      end
   end

   // Register file; a bus write to PC takes priority over auto-increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_DST); i++) rf_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_DST); i++) begin
            if (we[i]) rf_q[i] <= bus_in;
         end
         if (!we[DST_PC] && pc_inc) rf_q[DST_PC] <= rf_q[DST_PC] + DATA_W'(PC_STEP);
`ifdef BUS_DEST_R0_ZERO_EN
         rf_q[DST_R0] <= '0;
`endif
      end
   end

   for (genvar g = 0; g < int'(NUM_GPR); g++) begin : g_gpr
      assign gpr_q[g*DATA_W +: DATA_W] = rf_q[g];
   end

   assign hi_q      = rf_q[DST_HI];
   assign lo_q      = rf_q[DST_LO];
   assign y_q       = rf_q[DST_Y];
   assign mar_q     = rf_q[DST_MAR];
   assign pc_q      = rf_q[DST_PC];
   assign mdr_q     = rf_q[DST_MDR];
   assign outport_q = rf_q[DST_OUTPORT];
   assign ir_q      = rf_q[DST_IR];
   assign pair_busy = (state_q == PAIR_LO);
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign wr_count  = cnt_q;
   assign wr_ready  = ready_q;

endmodule

// File: tb/tb_bus_dest_bank.sv
// Self-checking bench for bus_dest_bank: table of single writes with a
// scoreboard queue, then hand sequences for pairs, PC, errors, saturation, reset.
module tb_bus_dest_bank;
   import bus_dest_bank_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;

`ifdef BUS_DEST_R0_ZERO_EN
   localparam logic [31:0] R0_EXP = 32'h0000_0000;
`else
   localparam logic [31:0] R0_EXP = 32'hFFFF_FFFF;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [DW-1:0]     bus_in = '0;
   logic [4:0]        dcode = '0;
   logic              wr_valid = 1'b0;
   logic              wr_pair = 1'b0;
   logic              wr_ready;
   logic              pc_inc = 1'b0;
   logic              err_clr = 1'b0;
   logic [16*DW-1:0]  gpr_q;
   logic [DW-1:0]     hi_q, lo_q, y_q, mar_q, pc_q, mdr_q, outport_q, ir_q;
   logic              pair_busy, err;
   logic [4:0]        err_code;
   logic [CW-1:0]     wr_count;

   always #5 clk = ~clk;

   bus_dest_bank #(.DATA_W(DW), .PC_STEP(4), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .dcode(dcode),
      .wr_valid(wr_valid), .wr_pair(wr_pair), .wr_ready(wr_ready),
      .pc_inc(pc_inc), .err_clr(err_clr), .gpr_q(gpr_q),
      .hi_q(hi_q), .lo_q(lo_q), .y_q(y_q), .mar_q(mar_q), .pc_q(pc_q),
      .mdr_q(mdr_q), .outport_q(outport_q), .ir_q(ir_q),
      .pair_busy(pair_busy), .err(err), .err_code(err_code), .wr_count(wr_count)
   );

   typedef struct {
      logic        v;
      logic        p;
      logic [4:0]  c;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [4:0]    c;
      logic [31:0]   exp;
      logic [CW-1:0] cnt;
   } exp_t;

   int            total = 0;
   int            bad   = 0;
   logic [CW-1:0] m_cnt = '0;
   exp_t          sb[$];
   vec_t          tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] reg_of(input logic [4:0] c);
      case (c)
         5'd16:   return hi_q;
         5'd17:   return lo_q;
         5'd18:   return y_q;
         5'd19:   return mar_q;
         5'd20:   return pc_q;
         5'd21:   return mdr_q;
         5'd22:   return outport_q;
         5'd23:   return ir_q;
         default: return (c < 5'd16) ? gpr_q[int'(c)*DW +: DW] : 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic drive(input logic v, input logic p, input logic [4:0] c, input logic [31:0] d,
                        input logic inc, input logic clr, input logic acc);
      wr_valid = v; wr_pair = p; dcode = c; bus_in = d; pc_inc = inc; err_clr = clr;
      if (acc && m_cnt != '1) m_cnt = m_cnt + CW'(1);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      tbl[0]  = '{1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      tbl[1]  = '{1'b1, 1'b0, 5'd16, 32'h11111111, 32'h11111111};
      tbl[2]  = '{1'b1, 1'b0, 5'd17, 32'h22222222, 32'h22222222};
      tbl[3]  = '{1'b1, 1'b0, 5'd18, 32'h33333333, 32'h33333333};
      tbl[4]  = '{1'b1, 1'b0, 5'd19, 32'h44444444, 32'h44444444};
      tbl[5]  = '{1'b1, 1'b0, 5'd21, 32'h55555555, 32'h55555555};
      tbl[6]  = '{1'b1, 1'b0, 5'd22, 32'h66666666, 32'h66666666};
      tbl[7]  = '{1'b1, 1'b0, 5'd23, 32'h77777777, 32'h77777777};
      tbl[8]  = '{1'b1, 1'b0, 5'd15, 32'hF0F0F0F0, 32'hF0F0F0F0};
      tbl[9]  = '{1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, R0_EXP};
      tbl[10] = '{1'b1, 1'b0, 5'd5,  32'h12345678, 32'h12345678};
      tbl[11] = '{1'b1, 1'b1, 5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[12] = '{1'b0, 1'b0, 5'd7,  32'hBAD0BAD0, 32'h00000000};

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      check("rst_ready", 32'(wr_ready), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_count", 32'(wr_count), 32'h0);
      check("rst_pc", pc_q, 32'h0);
      check("rst_pair_busy", 32'(pair_busy), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("ready_after_rst", 32'(wr_ready), 32'h1);

      // Table of single-beat writes through the scoreboard
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v, tbl[i].p, tbl[i].c, tbl[i].d, 1'b0, 1'b0, tbl[i].v);
         sb.push_back('{tbl[i].c, tbl[i].exp, m_cnt});
         tick();
         e = sb.pop_front();
         check($sformatf("tbl%0d_reg", i), reg_of(e.c), e.exp);
         check($sformatf("tbl%0d_count", i), 32'(wr_count), 32'(e.cnt));
         check($sformatf("tbl%0d_pair_busy", i), 32'(pair_busy), 32'h0);
         if (i == 0) begin
            for (int r = 0; r < 24; r++) begin
               if (r != 5) check($sformatf("first_clean_r%0d", r), reg_of(5'(r)), 32'h0);
            end
         end
      end
      idle();

      // HI/LO pair with idle gap; code on the LO beat is ignored
      drive(1'b1, 1'b1, 5'd16, 32'h1, 1'b0, 1'b0, 1'b1);
      tick();
      check("pair_hi", hi_q, 32'h1);
      check("pair_busy_set", 32'(pair_busy), 32'h1);
      idle();
      tick();
      tick();
      check("pair_busy_hold", 32'(pair_busy), 32'h1);
      check("pair_lo_unwritten", lo_q, 32'h22222222);
      drive(1'b1, 1'b0, 5'd3, 32'h2, 1'b0, 1'b0, 1'b1);
      tick();
      check("pair_lo", lo_q, 32'h2);
      check("pair_r3_kept", reg_of(5'd3), 32'hA5A5A5A5);
      check("pair_busy_clr", 32'(pair_busy), 32'h0);
      check("pair_hi_kept", hi_q, 32'h1);
      check("pair_count", 32'(wr_count), 32'(m_cnt));
      // Invalid code riding on the LO beat still writes LO and raises no error
      drive(1'b1, 1'b1, 5'd16, 32'hAAAA, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 1'b0, 5'd27, 32'hBBBB, 1'b0, 1'b0, 1'b1);
      tick();
      check("pair2_lo", lo_q, 32'hBBBB);
      check("pair2_no_err", 32'(err), 32'h0);
      check("pair2_idle", 32'(pair_busy), 32'h0);

      // PC write, auto-increment, write-wins collision and wrap
      drive(1'b1, 1'b0, 5'd20, 32'h100, 1'b0, 1'b0, 1'b1);
      tick();
      check("pc_load", pc_q, 32'h100);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      check("pc_inc3", pc_q, 32'h10C);
      drive(1'b1, 1'b0, 5'd20, 32'h400, 1'b1, 1'b0, 1'b1);
      tick();
      check("pc_write_wins", pc_q, 32'h400);
      drive(1'b1, 1'b0, 5'd20, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("pc_wrap", pc_q, 32'h0);
      idle();

      // Invalid code: sticky error, ready drops, later beat refused, clear
      drive(1'b1, 1'b0, 5'd27, 32'hDEAD, 1'b0, 1'b0, 1'b1);
      tick();
      check("err_set", 32'(err), 32'h1);
      check("err_code", 32'(err_code), 32'd27);
      check("err_ready_low", 32'(wr_ready), 32'h0);
      check("err_counted", 32'(wr_count), 32'(m_cnt));
      drive(1'b1, 1'b0, 5'd6, 32'h66, 1'b0, 1'b0, 1'b0);
      tick();
      check("err_refused_r6", reg_of(5'd6), 32'h0);
      check("err_refused_count", 32'(wr_count), 32'(m_cnt));
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      check("err_cleared", 32'(err), 32'h0);
      check("err_ready_back", 32'(wr_ready), 32'h1);
      check("err_code_hold", 32'(err_code), 32'd27);
      idle();

      // Counter saturation at all-ones
      while (m_cnt != CW'(8'hFE)) begin
         drive(1'b1, 1'b0, 5'd1, 32'(m_cnt), 1'b0, 1'b0, 1'b1);
         tick();
      end
      idle();
      tick();
      check("cnt_preload", 32'(wr_count), 32'hFE);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 5'd2, 32'(k), 1'b0, 1'b0, 1'b1);
         tick();
      end
      idle();
      check("cnt_saturate", 32'(wr_count), 32'hFF);

      // Reset in the middle of a pair abandons it
      drive(1'b1, 1'b1, 5'd16, 32'h5, 1'b0, 1'b0, 1'b1);
      tick();
      check("rst_pair_entered", 32'(pair_busy), 32'h1);
      idle();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_lo", lo_q, 32'h0);
      check("rst_mid_hi", hi_q, 32'h0);
      check("rst_mid_pair_busy", 32'(pair_busy), 32'h0);
      check("rst_mid_ready", 32'(wr_ready), 32'h0);
      check("rst_mid_count", 32'(wr_count), 32'h0);
      m_cnt = '0;
      #1 rst_n = 1'b1;
      tick();
      check("rst_mid_ready_back", 32'(wr_ready), 32'h1);
      drive(1'b1, 1'b0, 5'd9, 32'h99, 1'b0, 1'b0, 1'b1);
      tick();
      check("post_rst_r9", reg_of(5'd9), 32'h99);
      check("post_rst_lo", lo_q, 32'h0);
      check("post_rst_count", 32'(wr_count), 32'(m_cnt));
      idle();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
